// File: rtl/alu_arb_pkg.sv
// Shared constants for the ALU arbiter: FSM state encodings, ALU op codes,
// default timeout and the grant-index width helper.
package alu_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_XOR  = 5'b00010;
  localparam logic [4:0] OP_SLL  = 5'b00011;
  localparam logic [4:0] OP_SRL  = 5'b00100;
  localparam logic [4:0] OP_SRA  = 5'b00101;
  localparam logic [4:0] OP_ADD  = 5'b00110;
  localparam logic [4:0] OP_SUB  = 5'b00111;
  localparam logic [4:0] OP_FMUL = 5'b01000;

  localparam int unsigned DEFAULT_TIMEOUT = 1024;

  // Grant index width; never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_pick
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned GW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [GW-1:0]      idx,
  output logic               any
);

  // Offsets are scanned in priority order; the modulo keeps the search inside
  // 0..NUM_REQ-1 for non-power-of-two requester counts.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!any && req[j] && (j == ((32'(ptr) + k) % NUM_REQ))) begin
          grant[j] = 1'b1;
          idx      = GW'(j);
          any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU between NUM_REQ requesters:
// accept, issue, wait for valid_alu (with timeout), respond.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [5*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_rs1_signed,
  input  logic [NUM_REQ-1:0]       req_rs2_signed,
  input  logic [NUM_REQ-1:0]       req_fp,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_result,
  output logic                     resp_error,
  output logic                     resp_timeout,
  output logic                     start_alu,
  output logic [WIDTH-1:0]         A,
  output logic [WIDTH-1:0]         B,
  output logic [4:0]               op,
  output logic                     rs1_signed,
  output logic                     rs2_signed,
  output logic                     operation_ieee754_or_integer,
  input  logic                     busy_alu,
  input  logic                     valid_alu,
  input  logic                     error_alu,
  input  logic [WIDTH-1:0]         result
);

  localparam int unsigned GW = idx_width(NUM_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]         state;
  logic [GW-1:0]      rr_ptr;
  logic [GW-1:0]      grant;
  logic [CW-1:0]      cnt;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [GW-1:0]      pick_idx;
  logic               pick_any;

  logic [4:0]         sel_op;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               sel_s1;
  logic               sel_s2;
  logic               sel_fp;

  // ALU busy is status only; sequencing relies solely on valid_alu.
  logic               unused_busy;
  assign unused_busy = busy_alu;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .GW     (GW)
  ) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .grant(pick_onehot),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    sel_s1 = 1'b0;
    sel_s2 = 1'b0;
    sel_fp = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == GW'(i)) begin
        sel_op = req_op[5*i +: 5];
        sel_a  = req_a[WIDTH*i +: WIDTH];
        sel_b  = req_b[WIDTH*i +: WIDTH];
        sel_s1 = req_rs1_signed[i];
        sel_s2 = req_rs2_signed[i];
        sel_fp = req_fp[i];
      end
    end
  end

  assign req_ready = (state == ST_IDLE) ? pick_onehot : '0;
  assign start_alu = (state == ST_ISSUE);

  always_comb begin
    resp_valid = '0;
    if (state == ST_RESP) resp_valid[grant] = 1'b1;
  end

  // Operand registers are loaded only on accept, so they stay stable from
  // ISSUE through RESP for multi-beat ALU ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                        <= ST_IDLE;
      rr_ptr                       <= '0;
      grant                        <= '0;
      cnt                          <= '0;
      A                            <= '0;
      B                            <= '0;
      op                           <= '0;
      rs1_signed                   <= 1'b0;
      rs2_signed                   <= 1'b0;
      operation_ieee754_or_integer <= 1'b0;
      resp_result                  <= '0;
      resp_error                   <= 1'b0;
      resp_timeout                 <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant                        <= pick_idx;
            A                            <= sel_a;
            B                            <= sel_b;
            op                           <= sel_op;
            rs1_signed                   <= sel_s1;
            rs2_signed                   <= sel_s2;
            operation_ieee754_or_integer <= sel_fp;
            state                        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (valid_alu) begin
            resp_result  <= result;
            resp_error   <= error_alu;
            resp_timeout <= 1'b0;
            state        <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            resp_result  <= '0;
            resp_error   <= 1'b1;
            resp_timeout <= 1'b1;
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          rr_ptr <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level reference model with a
// per-cycle compare process, an ALU stand-in, and directed literal checks.
module tb_alu_arbiter;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]   req_valid, req_ready, req_rs1_signed, req_rs2_signed, req_fp, resp_valid;
  logic [5*N-1:0] req_op;
  logic [W*N-1:0] req_a, req_b;
  logic [W-1:0]   resp_result, A, B, result;
  logic           resp_error, resp_timeout, start_alu, rs1_signed, rs2_signed;
  logic           operation_ieee754_or_integer, busy_alu, valid_alu, error_alu;
  logic [4:0]     op;

  alu_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .req_rs1_signed(req_rs1_signed), .req_rs2_signed(req_rs2_signed), .req_fp(req_fp),
    .resp_valid(resp_valid), .resp_result(resp_result), .resp_error(resp_error),
    .resp_timeout(resp_timeout), .start_alu(start_alu), .A(A), .B(B), .op(op),
    .rs1_signed(rs1_signed), .rs2_signed(rs2_signed),
    .operation_ieee754_or_integer(operation_ieee754_or_integer),
    .busy_alu(busy_alu), .valid_alu(valid_alu), .error_alu(error_alu), .result(result)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] alu_fn(logic [4:0] o, logic [W-1:0] a, logic [W-1:0] b);
    case (o)
      5'b00000: return a & b;
      5'b00001: return a | b;
      5'b00010: return a ^ b;
      5'b00110: return a + b;
      5'b00111: return a - b;
      5'b01000: return a * b;
      default:  return a;
    endcase
  endfunction

  // ALU stand-in: valid_alu alu_lat cycles after start (0 = never), plus an
  // optional spurious pulse on cycle spur.
  int          alu_lat = 3;
  bit          alu_err = 1'b0;
  int          due     = -1;
  int          spur    = -1;
  logic [W-1:0] alu_res = '0;

  initial begin
    valid_alu = 1'b0; error_alu = 1'b0; result = '0; busy_alu = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      valid_alu = (cyc == due) || (cyc == spur);
      error_alu = (cyc == due) && alu_err;
      result    = (cyc == due) ? alu_res : '1;
      busy_alu  = (due > cyc);
    end
  end

  // Reference model state (transaction level)
  bit           m_busy = 1'b0;
  int           m_acc = 0, m_resp = -1, m_g = 0, m_ptr = 0;
  logic [4:0]   m_op = '0;
  logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic         m_s1 = 1'b0, m_s2 = 1'b0, m_fp = 1'b0;
  logic [W-1:0] h_res = '0;
  logic         h_err = 1'b0, h_to = 1'b0;

  // Observation log for directed checks
  int           acc_cnt = 0, last_acc_cyc = 0, last_acc_who = -1, start_cyc = 0;
  int           resp_cnt = 0, resp_cyc = 0, resp_who = -1;
  logic [W-1:0] resp_res = '0;
  logic         resp_err = 1'b0, resp_to = 1'b0;

  always @(negedge clk) begin : chk
    logic [N-1:0] e_ready, e_rv;
    logic         e_start;
    int           g, j;
    e_ready = '0; e_rv = '0; e_start = 1'b0; g = -1;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
      if (g >= 0) e_ready[g] = 1'b1;
    end else begin
      e_start = (cyc == m_acc + 1);
      if (cyc == m_resp) e_rv[m_g] = 1'b1;
    end

    check("req_ready", req_ready, e_ready);
    check("resp_valid", resp_valid, e_rv);
    check("start_alu", start_alu, e_start);
    check("resp_result", resp_result, h_res);
    check("resp_error", resp_error, h_err);
    check("resp_timeout", resp_timeout, h_to);
    check("alu_A", A, m_a);
    check("alu_B", B, m_b);
    check("alu_op", op, m_op);
    check("alu_flags", {rs1_signed, rs2_signed, operation_ieee754_or_integer}, {m_s1, m_s2, m_fp});

    for (int k = 0; k < N; k++) begin
      if (req_ready[k] && req_valid[k]) begin
        acc_cnt++; last_acc_cyc = cyc; last_acc_who = k;
      end
      if (resp_valid[k]) begin
        resp_cnt++; resp_cyc = cyc; resp_who = k;
        resp_res = resp_result; resp_err = resp_error; resp_to = resp_timeout;
      end
    end
    if (start_alu) start_cyc = cyc;

    if (rst) begin
      m_busy = 1'b0; m_ptr = 0; m_resp = -1;
      m_op = '0; m_a = '0; m_b = '0; m_s1 = 1'b0; m_s2 = 1'b0; m_fp = 1'b0;
      h_res = '0; h_err = 1'b0; h_to = 1'b0;
      due = -1;
    end else begin
      if (!m_busy && g >= 0) begin
        m_busy = 1'b1; m_acc = cyc; m_g = g; m_resp = -1;
        m_op = req_op[5*g +: 5];
        m_a  = req_a[W*g +: W];
        m_b  = req_b[W*g +: W];
        m_s1 = req_rs1_signed[g]; m_s2 = req_rs2_signed[g]; m_fp = req_fp[g];
        m_res = alu_fn(m_op, m_a, m_b);
      end else if (m_busy) begin
        if (cyc == m_resp) begin
          m_busy = 1'b0;
          m_ptr  = (m_g + 1) % N;
        end else if (m_resp < 0 && cyc >= m_acc + 2) begin
          if (valid_alu) begin
            m_resp = cyc + 1; h_res = m_res; h_err = error_alu; h_to = 1'b0;
          end else if (cyc == m_acc + 2 + TO - 1) begin
            m_resp = cyc + 1; h_res = '0; h_err = 1'b1; h_to = 1'b1;
          end
        end
      end
      if (start_alu && alu_lat > 0) begin
        due = cyc + alu_lat;
        alu_res = alu_fn(op, A, B);
      end
    end
  end

  task automatic set_req(int i, logic [4:0] o, logic [W-1:0] a, logic [W-1:0] b,
                         logic s1, logic s2, logic f);
    req_op[5*i +: 5] = o;
    req_a[W*i +: W]  = a;
    req_b[W*i +: W]  = b;
    req_rs1_signed[i] = s1;
    req_rs2_signed[i] = s2;
    req_fp[i]         = f;
    req_valid[i]      = 1'b1;
  endtask

  task automatic wait_acc(int target, int budget, string name);
    int t = 0;
    while (acc_cnt < target && t < budget) begin
      @(negedge clk); #1; t++;
    end
    if (acc_cnt < target) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no accept within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_resp(int target, int budget, string name);
    int t = 0;
    while (resp_cnt < target && t < budget) begin
      @(negedge clk); #1; t++;
    end
    if (resp_cnt < target) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no response within %0d cycles", name, budget);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    rst = 1'b1;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    req_rs1_signed = '0; req_rs2_signed = '0; req_fp = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk); #1;
    check("reset_A", A, 32'h0);
    check("reset_ready", req_ready, 2'b00);
    tick();

    // Single ADD on requester 0, ALU valid 3 cycles after start
    alu_lat = 3;
    set_req(0, 5'b00110, 32'hA3B52F1D, 32'h7D3E9A0B, 1'b0, 1'b0, 1'b0);
    wait_acc(1, 10, "t1_accept");
    tick(); req_valid = '0;
    wait_resp(1, 20, "t1_resp");
    check("t1_start_lat", start_cyc - last_acc_cyc, 1);
    check("t1_resp_lat", resp_cyc - last_acc_cyc, 5);
    check("t1_who", resp_who, 0);
    check("t1_result", resp_res, 32'h20F3C928);
    check("t1_error", resp_err, 1'b0);

    // Both requesters hold requests after reset: grants alternate 0,1,0,1
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    set_req(0, 5'b00110, 32'hA3B52F1D, 32'h7D3E9A0B, 1'b0, 1'b0, 1'b0);
    set_req(1, 5'b00111, 32'hF1C2D84E, 32'h923467AF, 1'b1, 1'b0, 1'b0);
    base = resp_cnt;
    for (int r = 0; r < 4; r++) begin
      wait_resp(base + r + 1, 30, "t2_resp");
      check("t2_who", resp_who, r % 2);
      check("t2_result", resp_res, (r % 2) ? 32'h5F8E709F : 32'h20F3C928);
    end
    tick(); req_valid = '0;

    // ALU never answers: timeout 16 cycles after entering WAIT
    alu_lat = 0;
    set_req(0, 5'b00110, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b0);
    base = resp_cnt;
    wait_acc(acc_cnt + 1, 10, "t3_accept");
    tick(); req_valid = '0;
    wait_resp(base + 1, 40, "t3_resp");
    check("t3_resp_lat", resp_cyc - (last_acc_cyc + 2), 16);
    check("t3_error", resp_err, 1'b1);
    check("t3_timeout", resp_to, 1'b1);
    check("t3_result", resp_res, 32'h0);

    // valid_alu on the exact timeout cycle wins
    alu_lat = 16;
    tick();
    set_req(1, 5'b00001, 32'h0F0F1234, 32'h30F00001, 1'b0, 1'b0, 1'b0);
    base = resp_cnt;
    wait_acc(acc_cnt + 1, 10, "t4_accept");
    check("t4_next_accepted_who", last_acc_who, 1);
    tick(); req_valid = '0;
    wait_resp(base + 1, 40, "t4_resp");
    check("t4_resp_lat", resp_cyc - last_acc_cyc, 18);
    check("t4_error", resp_err, 1'b0);
    check("t4_timeout", resp_to, 1'b0);
    check("t4_result", resp_res, 32'h3FFF1235);

    // Reset during WAIT abandons the op; round robin restarts at 0
    alu_lat = 3;
    tick();
    set_req(0, 5'b00000, 32'hFFFF0000, 32'h12345678, 1'b0, 1'b0, 1'b0);
    base = resp_cnt;
    wait_acc(acc_cnt + 1, 10, "t5a_accept");
    tick(); req_valid = '0;
    wait_resp(base + 1, 20, "t5a_resp");
    check("t5a_result", resp_res, 32'h12340000);
    alu_lat = 5;
    tick();
    set_req(1, 5'b00010, 32'h0000FFFF, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0);
    base = resp_cnt;
    wait_acc(acc_cnt + 1, 10, "t5b_accept");
    tick(); req_valid = '0;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk); #1;
    check("t5_post_rst_A", A, 32'h0);
    check("t5_post_rst_result", resp_result, 32'h0);
    check("t5_post_rst_start", start_alu, 1'b0);
    spur = cyc + 2;
    repeat (8) begin @(negedge clk); #1; end
    check("t5_no_resp", resp_cnt, base);
    alu_lat = 3;
    tick();
    set_req(0, 5'b00110, 32'h00000005, 32'h00000007, 1'b0, 1'b0, 1'b0);
    set_req(1, 5'b00111, 32'h00000005, 32'h00000007, 1'b0, 1'b0, 1'b0);
    wait_acc(acc_cnt + 1, 10, "t5c_accept");
    check("t5_first_after_rst", last_acc_who, 0);
    tick(); req_valid = '0;
    wait_resp(base + 1, 20, "t5c_resp");
    check("t5c_result", resp_res, 32'h0000000C);

    // FMUL with ALU error: error flagged, no timeout, operands held
    alu_lat = 4; alu_err = 1'b1;
    tick();
    set_req(1, 5'b01000, 32'h3FC00000, 32'h40200000, 1'b1, 1'b1, 1'b1);
    base = resp_cnt;
    wait_acc(acc_cnt + 1, 10, "t6_accept");
    tick(); req_valid = '0;
    wait_resp(base + 1, 20, "t6_resp");
    check("t6_who", resp_who, 1);
    check("t6_resp_lat", resp_cyc - last_acc_cyc, 6);
    check("t6_error", resp_err, 1'b1);
    check("t6_timeout", resp_to, 1'b0);
    alu_err = 1'b0;

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
